microcode_controller: RTL and testbench
=======================================

// Module: microcode_controller
// PURPOSE
//  Next-address controller for the microcode store: drives the CodeROM address,
//  latches the fetched microword into the pipeline register, and decodes its
//  sequencing fields (branch, call/return, loop counter, wait, halt) with condition test.
//  Sits between the 4096x56 code ROM (combinational read) and the datapath,
//  which receives the control field and returns condition flags.
// PARAMETERS
//  ADDR_W       12  microcode address width; also immediate and loop counter width
//  WORD_W       56  microword width
//  STACK_DEPTH   4  return-address stack entries
// PORTS
//  clock       in   1            system clock, rising edge
//  reset       in   1            asynchronous, active-low
//  start       in   1            begin execution at start_addr (honoured only when halted)
//  start_addr  in   ADDR_W       entry address
//  halted      out  1            1 = IDLE, 0 = RUN
//  rom_addr    out  ADDR_W       combinational ROM address for the next fetch
//  rom_data    in   WORD_W       ROM word at rom_addr, same cycle
//  cond_in     in   16           datapath condition flags
//  ctrl_out    out  WORD_W-21    pipeline[WORD_W-1:ADDR_W+9], control field to datapath
//  stack_err   out  1            sticky stack overflow/underflow flag
// BEHAVIOUR
//  Word fields: imm=[ADDR_W-1:0], op=[+3:+0 above imm], csel=next 4, cpol=next 1 (bit ADDR_W+8).
//  cond = (csel==0) ? 1 : cond_in[csel]^cpol.
//  Registers: pipeline, cur_addr (address of word in pipeline), ctr, stack, sp, state.
//  Reset: state=IDLE, pipeline=0, cur_addr=0, ctr=0, sp=0, stack_err=0, halted=1,
//   rom_addr=0, ctrl_out=0; takes effect immediately, including mid-program.
//  IDLE: rom_addr = start ? start_addr : 0; pipeline held at 0.
//   start=1 -> edge: pipeline<=rom_data, cur_addr<=start_addr, stack_err<=0, state RUN.
//  RUN, every edge: pipeline<=rom_data, cur_addr<=rom_addr. seq = cur_addr+1 (wraps mod 2^ADDR_W).
//   rom_addr by op:
//   0 CONT: seq
//   1 JUMP: cond ? imm : seq
//   2 CALL: cond ? imm : seq; if taken push seq
//   3 RET : cond ? pop : seq
//   4 LDCT: seq; ctr<=imm
//   5 LOOP: ctr!=0 ? imm (ctr<=ctr-1) : seq   -> LDCT N; body ending in LOOP runs N+1 passes
//   6 WAIT: cond ? seq : cur_addr (word re-fetched, ctrl_out re-presented)
//   7 HALT: edge -> state IDLE, pipeline<=0; rom_addr=0
//   8-15: treated as CONT.
//  Branch latency: target word is in pipeline on the edge after the branch word is.
//  start asserted in RUN is ignored.
//  Push with sp==STACK_DEPTH: push dropped, branch still taken, stack_err<=1.
//  RET taken with sp==0: rom_addr=0, stack_err<=1.
//  stack_err clears only on reset or accepted start.
// CONFIGURATION
//  UCTRL_BREAKPOINT_EN defined: adds input bkpt_addr[ADDR_W-1:0] and bkpt_en[1].
//   In RUN, rom_addr==bkpt_addr with bkpt_en=1 -> that word is not latched; state IDLE,
//   pipeline<=0. start resumes from start_addr.
//  Undefined: no extra ports, no breakpoint logic.
// TESTING
//  reset low mid-RUN -> halted=1, rom_addr=0x000, ctrl_out=0 without waiting for clock
//  start, start_addr=0x010; CONT@010, CONT@011, HALT@012 -> rom_addr 010,011,012,000;
//   halted=1 one edge after HALT latched
//  CALL 0x100 @020 (csel=0); RET @100 -> fetch 100 then 021; stack_err=0
//  LDCT 3 @030; body 031..032 with LOOP imm=031 @032 -> four passes, then fetch 033
//  JUMP imm=0x200 csel=5 cpol=0: cond_in[5]=0 -> seq; =1 -> 0x200;
//   WAIT csel=5: holds address until cond_in[5]=1
//  5 nested CALLs -> stack_err=1; 5 RETs -> 5th RET fetches 0x000;
//   next start clears stack_err

Source files
------------

// File: rtl/microcode_controller.sv
// microcode_controller: next-address sequencer for the microcode store.
// Drives the combinational ROM address, latches the fetched word into the
// pipeline register and decodes branch/call/return/loop/wait/halt fields.
// Optional feature macro: UCTRL_BREAKPOINT_EN (adds bkpt_addr/bkpt_en).
module microcode_controller #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WORD_W      = 56,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          start_addr,
  output logic                       halted,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [WORD_W-1:0]          rom_data,
  input  logic [15:0]                cond_in,
  output logic [WORD_W-ADDR_W-10:0]  ctrl_out,
  output logic                       stack_err
`ifdef UCTRL_BREAKPOINT_EN
  ,
  input  logic [ADDR_W-1:0]          bkpt_addr,
  input  logic                       bkpt_en
`endif
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  typedef enum logic [3:0] {
    OP_CONT = 4'd0,
    OP_JUMP = 4'd1,
    OP_CALL = 4'd2,
    OP_RET  = 4'd3,
    OP_LDCT = 4'd4,
    OP_LOOP = 4'd5,
    OP_WAIT = 4'd6,
    OP_HALT = 4'd7
  } op_e;

  state_e              state;
  state_e              state_nxt;
  logic [WORD_W-1:0]   pipeline;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   ctr;
  logic [ADDR_W-1:0]   stack [STACK_DEPTH];
  logic [SP_W-1:0]     sp;
  logic                err;

  // Decoded fields of the word currently in the pipeline
  logic [ADDR_W-1:0]   imm;
  logic [3:0]          op;
  logic [3:0]          csel;
  logic                cpol;
  logic                cond;
  logic [ADDR_W-1:0]   seq;
  logic [ADDR_W-1:0]   stack_top;
  logic                stack_full;
  logic                stack_empty;

  // Sequencing controls
  logic [ADDR_W-1:0]   next_addr;
  logic                fetch;
  logic                push;
  logic                pop;
  logic                ctr_load;
  logic                ctr_dec;
  logic                err_set;
  logic                err_clr;

  assign imm         = pipeline[ADDR_W-1:0];
  assign op          = pipeline[ADDR_W+3:ADDR_W];
  assign csel        = pipeline[ADDR_W+7:ADDR_W+4];
  assign cpol        = pipeline[ADDR_W+8];
  assign cond        = (csel == 4'd0) ? 1'b1 : (cond_in[csel] ^ cpol);
  assign seq         = cur_addr + ADDR_W'(1);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);
  assign stack_top   = stack[IDX_W'(sp - SP_W'(1))];

  assign halted    = (state == S_IDLE);
  assign ctrl_out  = pipeline[WORD_W-1:ADDR_W+9];
  assign stack_err = err;
  // Reset forces the visible address to zero at once; the state registers
  // are already cleared asynchronously so next_addr itself needs no gating.
  assign rom_addr  = reset ? next_addr : '0;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, next-address and sequencing side-effect decode
  always_comb begin
    state_nxt = state;
    next_addr = '0;
    fetch     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    ctr_load  = 1'b0;
    ctr_dec   = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_addr = start_addr;
          fetch     = 1'b1;
          err_clr   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        fetch     = 1'b1;
        next_addr = seq;
        case (op)
          OP_JUMP: if (cond) next_addr = imm;
          OP_CALL: begin
            if (cond) begin
              next_addr = imm;
              if (stack_full) err_set = 1'b1;
              else            push    = 1'b1;
            end
          end
          OP_RET: begin
            if (cond) begin
              if (stack_empty) begin
                next_addr = '0;
                err_set   = 1'b1;
              end else begin
                next_addr = stack_top;
                pop       = 1'b1;
              end
            end
          end
          OP_LDCT: ctr_load = 1'b1;
          OP_LOOP: begin
            if (ctr != '0) begin
              next_addr = imm;
              ctr_dec   = 1'b1;
            end
          end
          OP_WAIT: if (!cond) next_addr = cur_addr;
          OP_HALT: begin
            next_addr = '0;
            fetch     = 1'b0;
            state_nxt = S_IDLE;
          end
          default: ;
        endcase
`ifdef UCTRL_BREAKPOINT_EN
        if (fetch && bkpt_en && (next_addr == bkpt_addr)) begin
          fetch     = 1'b0;
          state_nxt = S_IDLE;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pipeline, current address, loop counter, stack pointer and sticky error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipeline <= '0;
      cur_addr <= '0;
      ctr      <= '0;
      sp       <= '0;
      err      <= 1'b0;
    end else begin
      pipeline <= fetch ? rom_data : '0;
      if (fetch) cur_addr <= next_addr;
      if (ctr_load)     ctr <= imm;
      else if (ctr_dec) ctr <= ctr - ADDR_W'(1);
      if (push)     sp <= sp + SP_W'(1);
      else if (pop) sp <= sp - SP_W'(1);
      if (err_clr)      err <= 1'b0;
      else if (err_set) err <= 1'b1;
    end
  end

  // Return-address storage; contents above sp are don't-care so no reset
  always_ff @(posedge clock) begin
    if (push) stack[IDX_W'(sp)] <= seq;
  end

endmodule

// File: tb/tb_microcode_controller.sv
// Self-checking bench for microcode_controller: directed programs with
// literal expectations plus randomized ROM/conditions against an
// instruction-level model.
module tb_microcode_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [11:0] start_addr = '0;
  logic        halted;
  logic [11:0] rom_addr;
  logic [55:0] rom_data;
  logic [15:0] cond_in = '0;
  logic [34:0] ctrl_out;
  logic        stack_err;
`ifdef UCTRL_BREAKPOINT_EN
  logic [11:0] bkpt_addr = '0;
  logic        bkpt_en = 1'b0;
`endif

  logic [55:0] rom [4096];
  assign rom_data = rom[rom_addr];

  microcode_controller #(
    .ADDR_W(12),
    .WORD_W(56),
    .STACK_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .start_addr(start_addr),
    .halted(halted),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .cond_in(cond_in),
    .ctrl_out(ctrl_out),
    .stack_err(stack_err)
`ifdef UCTRL_BREAKPOINT_EN
    ,
    .bkpt_addr(bkpt_addr),
    .bkpt_en(bkpt_en)
`endif
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- instruction-level model ----------------
  bit          m_run;
  logic [55:0] m_word;
  logic [11:0] m_cur;
  logic [11:0] m_ctr;
  logic [11:0] m_stk[$];
  bit          m_err;

  function automatic bit m_cond(input logic [55:0] w);
    int cs;
    cs = int'(w[19:16]);
    if (cs == 0) return 1'b1;
    return cond_in[cs] ^ w[20];
  endfunction

  function automatic logic [11:0] m_addr();
    logic [11:0] imm;
    logic [11:0] nxt;
    bit          c;
    if (!m_run) return start ? start_addr : 12'h000;
    imm = m_word[11:0];
    nxt = m_cur + 12'd1;
    c   = m_cond(m_word);
    case (int'(m_word[15:12]))
      1: if (c) return imm;
      2: if (c) return imm;
      3: if (c) return (m_stk.size() == 0) ? 12'h000 : m_stk[$];
      5: if (m_ctr != 0) return imm;
      6: if (!c) return m_cur;
      7: return 12'h000;
      default: ;
    endcase
    return nxt;
  endfunction

  logic [11:0] ma;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_run = 1'b0; m_word = '0; m_cur = '0; m_ctr = '0; m_err = 1'b0;
      m_stk.delete();
    end else begin
      ma = m_addr();
      if (!m_run) begin
        if (start) begin
          m_run = 1'b1; m_err = 1'b0; m_word = rom[ma]; m_cur = ma;
        end
      end else begin
        case (int'(m_word[15:12]))
          2: if (m_cond(m_word)) begin
               if (m_stk.size() == 4) m_err = 1'b1;
               else m_stk.push_back(m_cur + 12'd1);
             end
          3: if (m_cond(m_word)) begin
               if (m_stk.size() == 0) m_err = 1'b1;
               else void'(m_stk.pop_back());
             end
          4: m_ctr = m_word[11:0];
          5: if (m_ctr != 0) m_ctr = m_ctr - 12'd1;
          default: ;
        endcase
        if (int'(m_word[15:12]) == 7) begin
          m_run = 1'b0; m_word = '0;
        end else begin
          m_word = rom[ma]; m_cur = ma;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_halted", 64'(halted), 64'(!m_run));
      chk("m_rom_addr", 64'(rom_addr), reset ? 64'(m_addr()) : 64'h0);
      chk("m_ctrl_out", 64'(ctrl_out), 64'(m_word[55:21]));
      chk("m_stack_err", 64'(stack_err), 64'(m_err));
    end
  end

  // ---------------- directed helpers ----------------
  function automatic logic [55:0] mk(input int op, input int imm, input int cs, input int cp);
    logic [63:0] r;
    logic [55:0] w;
    r = {$urandom, $urandom};
    w = {r[34:0], cp[0], cs[3:0], op[3:0], imm[11:0]};
    return w;
  endfunction

  task automatic go(input string nm, input logic [11:0] sa, input logic [15:0] c);
    @(posedge clock); #1;
    start = 1'b1; start_addr = sa; cond_in = c;
    @(negedge clock);
    chk(nm, 64'(rom_addr), 64'(sa));
  endtask

  task automatic nxt(input string nm, input logic [11:0] e, input logic [15:0] c);
    @(posedge clock); #1;
    start = 1'b0; cond_in = c;
    @(negedge clock);
    chk(nm, 64'(rom_addr), 64'(e));
  endtask

  task automatic idle_chk(input string nm);
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk(nm, 64'(halted), 64'h1);
  endtask

  logic [11:0] loop_seq [10];
  logic [11:0] nest_seq [11];
  logic [34:0] wait_ctrl;

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = mk(7, 0, 0, 0);
    rom[12'h010] = mk(0, 0, 0, 0);
    rom[12'h011] = mk(0, 0, 0, 0);
    rom[12'h012] = mk(7, 0, 0, 0);
    rom[12'h020] = mk(2, 12'h100, 0, 0);
    rom[12'h100] = mk(3, 0, 0, 0);
    rom[12'h030] = mk(4, 3, 0, 0);
    rom[12'h031] = mk(0, 0, 0, 0);
    rom[12'h032] = mk(5, 12'h031, 0, 0);
    rom[12'h040] = mk(1, 12'h200, 5, 0);
    rom[12'h200] = mk(6, 0, 5, 0);
    rom[12'h050] = mk(2, 12'h060, 0, 0);
    rom[12'h060] = mk(2, 12'h070, 0, 0);
    rom[12'h070] = mk(2, 12'h080, 0, 0);
    rom[12'h080] = mk(2, 12'h090, 0, 0);
    rom[12'h090] = mk(2, 12'h0A0, 0, 0);
    rom[12'h0A0] = mk(3, 0, 0, 0);
    rom[12'h081] = mk(3, 0, 0, 0);
    rom[12'h071] = mk(3, 0, 0, 0);
    rom[12'h061] = mk(3, 0, 0, 0);
    rom[12'h051] = mk(3, 0, 0, 0);
    loop_seq = '{12'h031, 12'h032, 12'h031, 12'h032, 12'h031,
                 12'h032, 12'h031, 12'h032, 12'h033, 12'h000};
    nest_seq = '{12'h060, 12'h070, 12'h080, 12'h090, 12'h0A0, 12'h081,
                 12'h071, 12'h061, 12'h051, 12'h000, 12'h000};

    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clock);
    chk("rst_halted", 64'(halted), 64'h1);
    chk("rst_addr", 64'(rom_addr), 64'h0);
    chk("rst_ctrl", 64'(ctrl_out), 64'h0);
    chk("rst_err", 64'(stack_err), 64'h0);

    // straight-line then halt
    go("p1_start", 12'h010, 16'h0);
    nxt("p1_a", 12'h011, 16'h0);
    nxt("p1_b", 12'h012, 16'h0);
    nxt("p1_c", 12'h000, 16'h0);
    chk("p1_running", 64'(halted), 64'h0);
    idle_chk("p1_halted");

    // call / return
    go("p2_start", 12'h020, 16'h0);
    nxt("p2_call", 12'h100, 16'h0);
    nxt("p2_ret", 12'h021, 16'h0);
    chk("p2_err", 64'(stack_err), 64'h0);
    nxt("p2_halt", 12'h000, 16'h0);
    idle_chk("p2_halted");

    // counted loop: four passes of the body
    go("p3_start", 12'h030, 16'h0);
    for (int i = 0; i < 10; i++) nxt("p3_loop", loop_seq[i], 16'h0);
    idle_chk("p3_halted");

    // conditional jump and wait
    go("p4_start_nt", 12'h040, 16'h0);
    nxt("p4_jmp_nt", 12'h041, 16'h0);
    nxt("p4_halt_nt", 12'h000, 16'h0);
    idle_chk("p4_halted_nt");
    go("p4_start_t", 12'h040, 16'h0020);
    nxt("p4_jmp_t", 12'h200, 16'h0020);
    nxt("p4_wait_hold", 12'h200, 16'h0);
    wait_ctrl = ctrl_out;
    chk("p4_wait_ctrl", 64'(wait_ctrl), 64'(rom[12'h200][55:21]));
    nxt("p4_wait_hold2", 12'h200, 16'h0);
    chk("p4_wait_ctrl2", 64'(ctrl_out), 64'(wait_ctrl));
    nxt("p4_wait_go", 12'h201, 16'h0020);
    nxt("p4_wait_halt", 12'h000, 16'h0);
    idle_chk("p4_halted_t");

    // stack overflow then underflow
    go("p5_start", 12'h050, 16'h0);
    for (int i = 0; i < 11; i++) nxt("p5_nest", nest_seq[i], 16'h0);
    chk("p5_err_set", 64'(stack_err), 64'h1);
    idle_chk("p5_halted");
    chk("p5_err_sticky", 64'(stack_err), 64'h1);
    go("p5_restart", 12'h010, 16'h0);
    nxt("p5_rs_a", 12'h011, 16'h0);
    chk("p5_err_clr", 64'(stack_err), 64'h0);
    nxt("p5_rs_b", 12'h012, 16'h0);
    nxt("p5_rs_c", 12'h000, 16'h0);
    idle_chk("p5_rs_halted");

    // asynchronous reset mid-run, with start held high
    go("p6_start", 12'h020, 16'h0);
    nxt("p6_call", 12'h100, 16'h0);
    @(posedge clock); #1;
    #2 reset = 1'b0; start = 1'b1; start_addr = 12'h123;
    #1;
    chk("p6_halted", 64'(halted), 64'h1);
    chk("p6_addr", 64'(rom_addr), 64'h0);
    chk("p6_ctrl", 64'(ctrl_out), 64'h0);
    chk("p6_err", 64'(stack_err), 64'h0);
    @(posedge clock); #1;
    start = 1'b0; reset = 1'b1;

    // randomized program store and conditions
    for (int i = 0; i < 4096; i++) rom[i] = mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)),
                                              int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      cond_in    = 16'($urandom);
      start      = ($urandom_range(0, 5) == 0);
      start_addr = 12'($urandom);
      if (i == 1700) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
